// File: rtl/rv_div_pkg.sv
// Shared types and constants for the sequential RV32M-style divider.
// Holds the op encoding, the FSM state encoding and the zero-divisor quotient.
package rv_div_pkg;

    typedef enum logic [1:0] {
        OpDiv  = 2'b00,
        OpDivu = 2'b01,
        OpRem  = 2'b10,
        OpRemu = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    // Wide enough for any supported N; users slice off the low N bits.
    localparam int unsigned MaxWidth = 64;
    localparam logic [MaxWidth-1:0] DivZeroQuot = '1;

endpackage

// File: rtl/seq_div_if.sv
// Request/response bundle between a divider client and seq_div.
// Carries the valid/ready handshakes, operands, result and flush.
interface seq_div_if #(
    parameter int unsigned N = 32
);
    import rv_div_pkg::*;

    logic         in_valid;
    logic         in_ready;
    op_e          op;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         flush;

    modport master (
        output in_valid, op, dividend, divisor, out_ready, flush,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, dividend, divisor, out_ready, flush,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/div_trial_sub.sv
// Trial subtraction for one restoring-division step.
// borrow is set when subtrahend exceeds minuend.
module div_trial_sub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per BUSY cycle, signed fix-up on entry
// to DONE, single-cycle handling of divide-by-zero and signed overflow.
module seq_div
    import rv_div_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input logic      clk,
    input logic      rst,
    seq_div_if.slave bus
);

    localparam int unsigned CntW = $clog2(N + 1);
    localparam logic [N-1:0] SignedMin = {1'b1, {(N-1){1'b0}}};

    state_e        state_q;
    op_e           op_q;
    logic [N-1:0]  quo_q, rem_q, dvs_q, result_q;
    logic [CntW-1:0] cnt_q;
    logic          negq_q, negr_q, out_valid_q;

    logic          is_signed, a_neg, b_neg, div_zero, overflow;
    logic [N-1:0]  a_mag, b_mag, special_res;
    logic [N:0]    trial_min, trial_sub, trial_diff;
    logic          borrow;
    logic [N-1:0]  quo_nxt, rem_nxt, quo_fix, rem_fix, final_res;
    logic          unused_diff_msb;

    always_comb begin
        is_signed = (bus.op == OpDiv) || (bus.op == OpRem);
        a_neg     = is_signed && bus.dividend[N-1];
        b_neg     = is_signed && bus.divisor[N-1];
        a_mag     = a_neg ? -bus.dividend : bus.dividend;
        b_mag     = b_neg ? -bus.divisor : bus.divisor;
        div_zero  = (bus.divisor == '0);
        overflow  = is_signed && (bus.dividend == SignedMin) && (bus.divisor == '1);
        if (div_zero) begin
            special_res = bus.op[1] ? bus.dividend : DivZeroQuot[N-1:0];
        end else begin
            special_res = bus.op[1] ? '0 : SignedMin;
        end
    end

    assign trial_min = {rem_q, quo_q[N-1]};
    assign trial_sub = {1'b0, dvs_q};

    div_trial_sub #(
        .W(N + 1)
    ) u_trial (
        .minuend   (trial_min),
        .subtrahend(trial_sub),
        .diff      (trial_diff),
        .borrow    (borrow)
    );

    // After a successful subtract the remainder is below the divisor, so bit N is always 0.
    assign unused_diff_msb = trial_diff[N];

    always_comb begin
        quo_nxt   = {quo_q[N-2:0], ~borrow};
        rem_nxt   = borrow ? trial_min[N-1:0] : trial_diff[N-1:0];
        quo_fix   = negq_q ? -quo_nxt : quo_nxt;
        rem_fix   = negr_q ? -rem_nxt : rem_nxt;
        final_res = ((op_q == OpRem) || (op_q == OpRemu)) ? rem_fix : quo_fix;
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OpDiv;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.flush) begin
            state_q     <= StIdle;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        op_q <= bus.op;
                        if (div_zero || overflow) begin
                            result_q <= special_res;
                            state_q  <= StDone;
                        end else begin
                            quo_q   <= a_mag;
                            rem_q   <= '0;
                            dvs_q   <= b_mag;
                            cnt_q   <= '0;
                            negq_q  <= a_neg ^ b_neg;
                            negr_q  <= a_neg;
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    quo_q <= quo_nxt;
                    rem_q <= rem_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(N - 1)) begin
                        result_q <= final_res;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    // out_valid is registered, so it trails DONE entry by one edge.
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter N, default 32, operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  divider idle and able to accept a request.
REQ-006 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-007 dividend  input  N  dividend operand (a).
REQ-008 divisor  input  N  divisor operand (b).
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  N  quotient for DIV/DIVU, remainder for REM/REMU.
REQ-012 flush  input  1  synchronous abort of any request in flight.

Function
REQ-013 FSM states: IDLE, BUSY, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Acceptance: in_valid && in_ready at a rising edge SHALL latch op and both operands.
REQ-015 Signed ops (DIV, REM) SHALL divide magnitudes, then negate: quotient when the operand signs differ, remainder when the dividend is negative.
REQ-016 Normal path: restoring division, one quotient bit per BUSY cycle, N iterations; each iteration uses an (N+1)-bit trial subtract of the shifted remainder minus the divisor magnitude.
REQ-017 Latency: with acceptance at edge 0, out_valid SHALL rise after edge N+1. Sign correction SHALL be folded into the transition to DONE.
REQ-018 Divide by zero: from IDLE go directly to DONE; quotient all ones (DIV and DIVU); remainder = dividend; out_valid SHALL rise after edge 1.
REQ-019 Signed overflow (DIV/REM, dividend = 2^(N-1) as signed minimum, divisor = all ones): go directly to DONE; quotient = 2^(N-1); remainder = 0; out_valid SHALL rise after edge 1.
REQ-020 DONE: out_valid = 1, and result SHALL remain stable until out_valid && out_ready; that edge SHALL return the FSM to IDLE. A new request SHALL be accepted no earlier than the next edge.
REQ-021 flush = 1 SHALL force IDLE at the next edge from any state, drop the result and leave out_valid low; flush SHALL take priority over acceptance.
REQ-022 Input changes while not IDLE SHALL NOT affect the result in flight.

Reset
REQ-023 While rst is high: state = IDLE, out_valid = 0, result = 0, internal quotient, remainder, divisor and counter registers = 0, and in_ready = 1 after reset release.
REQ-024 Reset asserted mid-operation SHALL abort immediately and asynchronously; no stale result SHALL appear after release.

Structure
REQ-025 Shared package rv_div_pkg SHALL hold the op encoding enum, the FSM state enum, and the localparam for the DIV/DIVU zero-divisor quotient (all ones).
REQ-026 One sub-module, div_trial_sub, SHALL be instantiated for the (N+1)-bit trial subtraction, outputting difference and borrow; the iteration counter SHALL be ceil(log2(N+1)) bits wide.

Verification
REQ-027 DIVU 100 / 7 -> result 14; REMU 100 / 7 -> result 2; out_valid rises exactly N+1 cycles after acceptance.
REQ-028 DIV -100 / 7 -> result -14; REM -100 / 7 -> result -2; DIV 100 / -7 -> -14; REM 100 / -7 -> 2.
REQ-029 DIVU 5 / 0 -> 0xFFFF_FFFF; REM 5 / 0 -> 5; DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM of the same operands -> 0; each completes in 1 cycle.
REQ-030 out_ready held low for 10 cycles in DONE -> result and out_valid held stable, in_ready stays 0, and new in_valid is ignored.
REQ-031 flush at BUSY iteration 10 -> IDLE next edge, no out_valid, and a following DIVU 0xFFFF_FFFF / 1 -> 0xFFFF_FFFF.
REQ-032 rst pulsed mid-BUSY -> out_valid 0 and in_ready 1 after release; back-to-back requests with out_ready tied high each complete at N+1 cycles plus 1 idle cycle.
